seg7_bcd_display: RTL

//  Parametrised multi-digit 7-segment display driver for the recorder front panel.

---
 rtl/seg7_bcd_display_if.sv | 25 ++
 rtl/seg7_bcd_display.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_display_if.sv
// Bundle of the 7-segment display driver's control, status and segment signals.
`timescale 1ns/1ps
interface seg7_bcd_display_if #(
  parameter int IN_W       = 16,
  parameter int NUM_DIGITS = 5
);
  logic                    i_start;
  logic [IN_W-1:0]         i_value;
  logic                    i_blank_lz;
  logic                    i_blink_en;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_overflow;
  logic [7*NUM_DIGITS-1:0] o_seg;

  modport master (
    output i_start, i_value, i_blank_lz, i_blink_en,
    input  o_busy, o_done, o_overflow, o_seg
  );

  modport slave (
    input  i_start, i_value, i_blank_lz, i_blink_en,
    output o_busy, o_done, o_overflow, o_seg
  );
endinterface

// File: rtl/seg7_bcd_display.sv
// Multi-digit active-low 7-segment driver: sequential double-dabble binary-to-BCD,
// leading-zero blanking, overflow dashes and a whole-display blink mask.
`timescale 1ns/1ps
module seg7_bcd_display #(
  parameter int IN_W       = 16,
  parameter int NUM_DIGITS = 5,
  parameter int BLINK_DIV  = 6000000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  seg7_bcd_display_if.slave    bus
);

  localparam int CW     = $clog2(IN_W + 1);
  localparam int BW     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int BCD_W  = 4 * (NUM_DIGITS + 1);
  localparam int SEG_W  = 7 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH
  } state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [BW-1:0]     blink_cnt_q;
  logic              blink_off_q;

  logic [BCD_W-1:0]  bcd_adj;
  logic [SEG_W-1:0]  image;
  logic              ovf_now;

  function automatic logic [6:0] seg7_code(input logic [3:0] n);
    logic [6:0] c;
    c = 7'h7f;
    case (n)
      4'd0: c = 7'h40;
      4'd1: c = 7'h79;
      4'd2: c = 7'h24;
      4'd3: c = 7'h30;
      4'd4: c = 7'h19;
      4'd5: c = 7'h12;
      4'd6: c = 7'h02;
      4'd7: c = 7'h78;
      4'd8: c = 7'h00;
      4'd9: c = 7'h10;
      default: c = 7'h7f;
    endcase
    return c;
  endfunction

  // Add-3 correction applied to every nibble before the shift.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS + 1; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                  bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
    end
  endgenerate

  assign ovf_now = |bcd_q[BCD_W-1 -: 4];

  // A digit is blanked only when it and every more significant digit are zero.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_img
      logic nz_above;
      logic blank_dig;
      assign nz_above  = |bcd_q[4*NUM_DIGITS-1 : 4*gi];
      assign blank_dig = bus.i_blank_lz && (gi != 0) && !nz_above;
      assign image[7*gi +: 7] = ovf_now   ? 7'h3f :
                                blank_dig ? 7'h7f :
                                seg7_code(bcd_q[4*gi +: 4]);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          bin_d   = bus.i_value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[IN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(IN_W - 1)) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        seg_d   = image;
        ovf_d   = ovf_now;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= '1;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Blink timebase runs continuously so enabling blink never restarts the phase.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      blink_off_q <= ~blink_off_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign bus.o_seg      = (bus.i_blink_en && blink_off_q) ? '1 : seg_q;
  assign bus.o_busy     = (state_q != S_IDLE);
  assign bus.o_done     = done_q;
  assign bus.o_overflow = ovf_q;

endmodule
